pc_branch_unit: RTL

PC_BRANCH_UNIT -- requirements
Module: pc_branch_unit

---
 rtl/pc_branch_unit.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pc_branch_unit.sv
// Program counter and branch/jump unit with a single delay slot.
// Tracks run/delay/halt and produces the link-register write for JAL/JALR/BxxAL.
module pc_branch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [4:0]  rt_field,
  input  logic [4:0]  rd_field,
  input  logic [15:0] imm16,
  input  logic [25:0] target26,
  input  logic [31:0] rs_value,
  input  logic [3:0]  branch_conditions,
  output logic [31:0] pc,
  output logic        link_en,
  output logic [4:0]  link_reg,
  output logic [31:0] link_data,
  output logic        active
);

  typedef enum logic [1:0] {RUN, DELAY, HALT} state_t;

  state_t      state_p0, state_nxt;
  logic [31:0] pc_p0, pc_nxt;
  logic [31:0] tgt_p0, tgt_nxt;
  logic [31:0] pc4;
  logic [31:0] jump_tgt;
  logic        taken;
  logic        is_link;
  logic        is_jalr;

  function automatic logic [31:0] branch_target(input logic [31:0] base, input logic [15:0] imm);
    logic signed [31:0] off;
    off = {{14{imm[15]}}, imm, 2'b00};
    return base + off;
  endfunction

  function automatic logic [31:0] region_target(input logic [31:0] base, input logic [25:0] idx);
    return {base[31:28], idx, 2'b00};
  endfunction

  assign pc4     = pc_p0 + 32'd4;
  assign is_jalr = (opcode == 6'b000000) && (funct == 6'b001001);

  always_comb begin
    taken    = 1'b0;
    is_link  = 1'b0;
    jump_tgt = branch_target(pc4, imm16);
    case (opcode)
      6'b000000: begin
        if (funct == 6'b001000 || funct == 6'b001001) begin
          taken    = 1'b1;
          jump_tgt = rs_value & ~32'd3;
          is_link  = is_jalr;
        end
      end
      6'b000001: begin
        case (rt_field)
          5'b00000: taken = branch_conditions[0];
          5'b10000: begin
            taken   = branch_conditions[0];
            is_link = 1'b1;
          end
          5'b00001: taken = branch_conditions[1] | branch_conditions[2];
          5'b10001: begin
            taken   = branch_conditions[1] | branch_conditions[2];
            is_link = 1'b1;
          end
          default: taken = 1'b0;
        endcase
      end
      6'b000010: begin
        taken    = 1'b1;
        jump_tgt = region_target(pc4, target26);
      end
      6'b000011: begin
        taken    = 1'b1;
        jump_tgt = region_target(pc4, target26);
        is_link  = 1'b1;
      end
      6'b000100: taken = branch_conditions[3];
      6'b000101: taken = ~branch_conditions[3];
      6'b000110: taken = branch_conditions[0] | branch_conditions[1];
      6'b000111: taken = branch_conditions[2];
      default:   taken = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state_p0;
    pc_nxt    = pc_p0;
    tgt_nxt   = tgt_p0;
    if (advance) begin
      case (state_p0)
        RUN: begin
          pc_nxt = pc4;
          if (taken) begin
            tgt_nxt   = jump_tgt;
            state_nxt = DELAY;
          end
        end
        // A branch sitting in the delay slot never redirects; only the latched target counts.
        DELAY: begin
          pc_nxt    = tgt_p0;
          state_nxt = (tgt_p0 == 32'd0) ? HALT : RUN;
        end
        default: state_nxt = state_p0;
      endcase
    end
  end

  // p0: architectural PC / state / latched target
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= RUN;
      pc_p0    <= RESET_VECTOR;
      tgt_p0   <= 32'd0;
    end else begin
      state_p0 <= state_nxt;
      pc_p0    <= pc_nxt;
      tgt_p0   <= tgt_nxt;
    end
  end

  assign pc        = pc_p0;
  assign active    = (state_p0 != HALT);
  assign link_en   = advance & is_link & (state_p0 != HALT);
  assign link_reg  = is_jalr ? rd_field : 5'd31;
  assign link_data = pc_p0 + 32'd8;

endmodule
